// File: rtl/counter_xn_pkg.sv
// Shared definitions for counter_xn: channel mode encodings, ctrl register bit
// positions and the channel-index width helper.
package counter_xn_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_SQUARE   = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IE      = 3;
  localparam int unsigned CTRL_CLR     = 4;
  localparam int unsigned CTRL_PSC_LO  = 8;

  // A single-channel build still needs a one-bit channel field.
  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/counter_xn_if.sv
// MIO bus view of the counter block: write strobe, register/channel select,
// write data, readback channel select and the registered readback count.
interface counter_xn_if
  import counter_xn_pkg::*;
#(
  parameter int NCH = 3,
  parameter int CW  = 32
);
  localparam int CHW = ch_w(NCH);

  logic           counter_we;
  logic [CHW:0]   counter_sel;
  logic [31:0]    counter_val;
  logic [CHW-1:0] rd_ch;
  logic [CW-1:0]  counter_out;

  modport master (
    output counter_we, counter_sel, counter_val, rd_ch,
    input  counter_out
  );

  modport slave (
    input  counter_we, counter_sel, counter_val, rd_ch,
    output counter_out
  );
endinterface

// File: rtl/counter_xn_ch.sv
// One down-counter channel: tick edge detect, optional prescaler, count/reload,
// done output and sticky flag. Prescaler present only with COUNTER_XN_PRESCALE_EN.
module counter_xn_ch
  import counter_xn_pkg::*;
#(
  parameter int CW  = 32,
  parameter int PSW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_i,
  input  logic          wr_reload_i,
  input  logic          wr_ctrl_i,
  input  logic [31:0]   val_i,
  output logic [CW-1:0] count_o,
  output logic          done_o,
  output logic          irq_o
);

  logic          tq_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] reload_q, reload_d;
  logic          en_q, en_d;
  logic          ie_q, ie_d;
  logic          flag_q, flag_d;
  logic          done_q, done_d;
  mode_e         mode_q, mode_d;
  logic          edge_s;
  logic          tick_eff;
  logic          unused_val;

  assign edge_s     = tick_i & ~tq_q;
  assign unused_val = ^{val_i, {PSW{1'b0}}};

`ifdef COUNTER_XN_PRESCALE_EN
  logic [PSW-1:0] psc_q, psc_d;
  logic [PSW-1:0] pval_q, pval_d;

  always_comb begin
    psc_d    = psc_q;
    pval_d   = pval_q;
    tick_eff = 1'b0;
    if (wr_reload_i) begin
      psc_d = '0;
    end else if (wr_ctrl_i) begin
      pval_d = val_i[CTRL_PSC_LO +: PSW];
      if (pval_d != pval_q) psc_d = '0;
    end else if (edge_s && en_q && (mode_q != MODE_RSVD)) begin
      if (psc_q == pval_q) begin
        psc_d    = '0;
        tick_eff = 1'b1;
      end else begin
        psc_d = psc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q  <= '0;
      pval_q <= '0;
    end else begin
      psc_q  <= psc_d;
      pval_q <= pval_d;
    end
  end
`else
  assign tick_eff = edge_s & en_q & (mode_q != MODE_RSVD) & ~(wr_reload_i | wr_ctrl_i);
`endif

  // Bus writes take priority over a same-cycle tick, which is then lost.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    en_d     = en_q;
    mode_d   = mode_q;
    ie_d     = ie_q;
    flag_d   = flag_q;
    done_d   = (mode_q == MODE_PERIODIC) ? 1'b0 : done_q;
    if (wr_reload_i) begin
      reload_d = val_i[CW-1:0];
      count_d  = val_i[CW-1:0];
      done_d   = 1'b0;
      flag_d   = 1'b0;
    end else if (wr_ctrl_i) begin
      en_d   = val_i[CTRL_EN];
      mode_d = mode_e'(val_i[CTRL_MODE_HI:CTRL_MODE_LO]);
      ie_d   = val_i[CTRL_IE];
      if (val_i[CTRL_CLR]) flag_d = 1'b0;
    end else if (tick_eff && (count_q != '0) && (reload_q != '0)) begin
      if (count_q == CW'(1)) begin
        flag_d = 1'b1;
        case (mode_q)
          MODE_ONESHOT: begin
            count_d = '0;
            done_d  = 1'b1;
          end
          MODE_PERIODIC: begin
            count_d = reload_q;
            done_d  = 1'b1;
          end
          MODE_SQUARE: begin
            count_d = reload_q;
            done_d  = ~done_q;
          end
          default: ;
        endcase
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tq_q     <= 1'b0;
      count_q  <= '0;
      reload_q <= '0;
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      ie_q     <= 1'b0;
      flag_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tq_q     <= tick_i;
      count_q  <= count_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      ie_q     <= ie_d;
      flag_q   <= flag_d;
      done_q   <= done_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = done_q & (mode_q != MODE_RSVD);
  assign irq_o   = flag_q & ie_q;

endmodule

// File: rtl/counter_xn.sv
// NCH-channel down-counter timer behind the MIO bus: select decode, channel
// array, registered readback mux and combined irq. Option: COUNTER_XN_PRESCALE_EN.
module counter_xn
  import counter_xn_pkg::*;
#(
  parameter int NCH = 3,
  parameter int CW  = 32,
  parameter int PSW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   tick_in,
  counter_xn_if.slave      bus,
  output logic [NCH-1:0]   counter_done,
  output logic             irq
);

  localparam int CHW = ch_w(NCH);

  logic [CHW-1:0] wch;
  logic           wsel_ctrl;
  logic [CW-1:0]  count_s [NCH];
  logic [NCH-1:0] irq_s;
  logic [CW-1:0]  out_q, out_d;

  assign wch       = bus.counter_sel[CHW-1:0];
  assign wsel_ctrl = bus.counter_sel[CHW];

  // Indices at or above NCH match no instance, so such writes fall away.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic hit;
    assign hit = bus.counter_we && (wch == CHW'(g));

    counter_xn_ch #(
      .CW  (CW),
      .PSW (PSW)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (tick_in[g]),
      .wr_reload_i (hit & ~wsel_ctrl),
      .wr_ctrl_i   (hit & wsel_ctrl),
      .val_i       (bus.counter_val),
      .count_o     (count_s[g]),
      .done_o      (counter_done[g]),
      .irq_o       (irq_s[g])
    );
  end

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.rd_ch == CHW'(i)) out_d = count_s[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign bus.counter_out = out_q;
  assign irq             = |irq_s;

endmodule

// File: tb/tb_counter_xn.sv
// Directed bench for counter_xn (NCH=3, CW=32): one-shot, periodic, square,
// write/tick collision, invalid channel, reserved mode, prescaler and reset.
module tb_counter_xn;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] tick;
  logic [2:0] done;
  logic       irq;
  int         n_chk  = 0;
  int         n_pass = 0;

  counter_xn_if #(.NCH(3), .CW(32)) bus ();

  counter_xn #(.NCH(3), .CW(32), .PSW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_in      (tick),
    .bus          (bus),
    .counter_done (done),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_hi(input int ch);
    tick[ch] = 1'b1;
    step();
  endtask

  task automatic tick_lo(input int ch);
    tick[ch] = 1'b0;
    step();
  endtask

  task automatic pulses(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      tick_hi(ch);
      tick_lo(ch);
    end
  endtask

  task automatic wr(input logic [2:0] sel, input logic [31:0] val);
    bus.counter_we  = 1'b1;
    bus.counter_sel = sel;
    bus.counter_val = val;
    step();
    bus.counter_we  = 1'b0;
  endtask

  task automatic rd_check(input string tag, input int ch, input logic [31:0] exp);
    bus.rd_ch = 2'(ch);
    step();
    check(tag, bus.counter_out, exp);
  endtask

  initial begin
    rst             = 1'b1;
    tick            = '0;
    bus.counter_we  = 1'b0;
    bus.counter_sel = '0;
    bus.counter_val = '0;
    bus.rd_ch       = '0;
    step(2);
    rst = 1'b0;
    step();
    check("rst_out",  bus.counter_out, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_irq",  32'(irq), 32'd0);

    // ch0 one-shot, reload 3
    wr(3'b000, 32'd3);
    wr(3'b100, 32'h01);
    rd_check("os_load", 0, 32'd3);
    pulses(0, 2);
    rd_check("os_cnt2", 0, 32'd1);
    check("os_done_early", 32'(done), 32'd0);
    tick_hi(0);
    check("os_done", 32'(done), 32'b001);
    tick_lo(0);
    rd_check("os_cnt0", 0, 32'd0);
    pulses(0, 1);
    check("os_hold_done", 32'(done), 32'b001);
    rd_check("os_hold_cnt", 0, 32'd0);
    check("os_noirq", 32'(irq), 32'd0);

    // ch1 periodic with irq, reload 2
    wr(3'b001, 32'd2);
    wr(3'b101, 32'h0B);
    tick_hi(1);
    tick_lo(1);
    check("per_e1_done", 32'(done), 32'b001);
    check("per_e1_irq", 32'(irq), 32'd0);
    tick_hi(1);
    check("per_pulse1", 32'(done), 32'b011);
    check("per_irq", 32'(irq), 32'd1);
    tick_lo(1);
    check("per_pulse_end", 32'(done), 32'b001);
    rd_check("per_reload", 1, 32'd2);
    pulses(1, 1);
    tick_hi(1);
    check("per_pulse2", 32'(done), 32'b011);
    tick_lo(1);
    wr(3'b101, 32'h1B);
    check("per_irq_clr", 32'(irq), 32'd0);

    // ch2 square, reload 4
    wr(3'b010, 32'd4);
    wr(3'b110, 32'h05);
    pulses(2, 3);
    check("sq_e3", 32'(done[2]), 32'd0);
    pulses(2, 1);
    check("sq_e4", 32'(done[2]), 32'd1);
    pulses(2, 4);
    check("sq_e8", 32'(done[2]), 32'd0);
    pulses(2, 4);
    check("sq_e12", 32'(done[2]), 32'd1);
    wr(3'b010, 32'd0);
    check("sq_rl0_done", 32'(done[2]), 32'd0);
    pulses(2, 2);
    check("sq_frozen_done", 32'(done[2]), 32'd0);
    rd_check("sq_frozen_cnt", 2, 32'd0);

    // reload write coincident with a tick edge on ch0
    wr(3'b000, 32'd5);
    check("coll_done_clr", 32'(done[0]), 32'd0);
    tick[0]         = 1'b1;
    bus.counter_we  = 1'b1;
    bus.counter_sel = 3'b000;
    bus.counter_val = 32'd7;
    step();
    bus.counter_we  = 1'b0;
    tick_lo(0);
    rd_check("coll_cnt", 0, 32'd7);
    pulses(0, 1);
    rd_check("coll_dec", 0, 32'd6);

    // out-of-range channel 3
    wr(3'b011, 32'd9);
    wr(3'b111, 32'h0F);
    rd_check("inv_ch0", 0, 32'd6);
    rd_check("inv_ch1", 1, 32'd2);
    rd_check("inv_rd", 3, 32'd0);

    // reserved mode freezes ch0
    wr(3'b100, 32'h07);
    pulses(0, 2);
    rd_check("rsvd_cnt", 0, 32'd6);
    check("rsvd_done", 32'(done[0]), 32'd0);

`ifdef COUNTER_XN_PRESCALE_EN
    // P=2 periodic, reload 1: pulse every third edge
    wr(3'b001, 32'd1);
    wr(3'b101, 32'h203);
    pulses(1, 2);
    check("psc_e2", 32'(done[1]), 32'd0);
    tick_hi(1);
    check("psc_e3", 32'(done[1]), 32'd1);
    tick_lo(1);
    pulses(1, 2);
    tick_hi(1);
    check("psc_e6", 32'(done[1]), 32'd1);
    tick_lo(1);
`endif

    // reset while a flag is pending
    wr(3'b001, 32'd1);
    wr(3'b101, 32'h0B);
    pulses(1, 1);
    check("pre_rst_irq", 32'(irq), 32'd1);
    bus.rd_ch = 2'd0;
    step();
    check("pre_rst_out", bus.counter_out, 32'd6);
    rst = 1'b1;
    step();
    check("rst_mid_out", bus.counter_out, 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    pulses(1, 1);
    check("post_rst_irq", 32'(irq), 32'd0);
    rd_check("post_rst_cnt", 1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
